// File: rtl/ro_puf_pkg.sv
// ro_puf_pkg
// Shared definitions for the ring-oscillator PUF sequencer: the FSM state
// encoding, default sizing constants and a small helper used to size the
// phase timer.
package ro_puf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        SETTLE,
        COMPARE,
        DONE
    } ro_puf_state_t;

    localparam int SEL_W_DEF   = 5;
    localparam int COUNT_W_DEF = 16;
    localparam int N_BITS_DEF  = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ro_puf_pair_sel.sv
// ro_puf_pair_sel
// Combinational oscillator pair selection for pair index k.
//   challenge [2*SEL_W-1:0] : {base B, base A}
//   k         [K_W-1:0]     : pair index
//   sel_a     [SEL_W-1:0]   : (A + k) mod 2**SEL_W
//   sel_b     [SEL_W-1:0]   : (B + k) mod 2**SEL_W, bumped by one if it
//                             would select the same oscillator as sel_a
module ro_puf_pair_sel
    import ro_puf_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEF,
    parameter int K_W   = 3
) (
    input  logic [2*SEL_W-1:0] challenge,
    input  logic [K_W-1:0]     k,
    output logic [SEL_W-1:0]   sel_a,
    output logic [SEL_W-1:0]   sel_b
);

    logic [SEL_W-1:0] base_a;
    logic [SEL_W-1:0] base_b;
    logic [SEL_W-1:0] k_ext;
    logic [SEL_W-1:0] raw_b;

    assign base_a = challenge[SEL_W-1:0];
    assign base_b = challenge[2*SEL_W-1:SEL_W];
    assign k_ext  = SEL_W'(k);

    // Additions are SEL_W wide, so the modulo wrap falls out of truncation.
    assign sel_a = base_a + k_ext;
    assign raw_b = base_b + k_ext;
    // Comparing an oscillator against itself carries no information.
    assign sel_b = (raw_b == sel_a) ? (sel_a + SEL_W'(1)) : raw_b;

endmodule

// File: rtl/ro_puf_ctrl.sv
// ro_puf_ctrl
// Sequencer for the ring-oscillator PUF datapath. For each of N_BITS pairs
// it selects two oscillators, clears the edge counters, gates the
// oscillators for WINDOW cycles, waits SETTLE_CYCLES, then shifts
// (count_a > count_b) into response[k].
//
// Ports
//   clk        : system clock
//   rst        : synchronous active-high reset
//   start      : evaluation request, honoured only in IDLE
//   challenge  : {base B, base A}, latched on start acceptance
//   count_a/_b : counter values from banks A/B, sampled only in COMPARE
//   sel_a/_b   : registered oscillator selects
//   ro_en      : oscillator enable
//   cnt_clr    : counter clear
//   busy       : evaluation in progress
//   done       : one-cycle pulse, response valid
//   response   : bit k from pair k, held until the next accepted start
//   unstable   : (RO_PUF_TIE_DETECT_EN only) bit k set when the two counts
//                of pair k differ by less than TIE_MARGIN
//
// Build option: define RO_PUF_TIE_DETECT_EN to add the unstable output and
// the TIE_MARGIN parameter.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start
// CLEAR   | counters held in clear, selects loaded
// RUN     | oscillators enabled for the measurement window
// SETTLE  | oscillators gated, counts settling
// COMPARE | one cycle: record the bit for pair k, advance k
// DONE    | one cycle: raise done, drop busy, back to IDLE
//
// ro_en, cnt_clr and sel_* are decoded from the state being left, so each
// lags the state by one cycle. That keeps them pure flop outputs and makes
// the counts sampled in COMPARE follow SETTLE_CYCLES of gated oscillators.
module ro_puf_ctrl
    import ro_puf_pkg::*;
#(
    parameter int N_BITS        = N_BITS_DEF,
    parameter int SEL_W         = SEL_W_DEF,
    parameter int COUNT_W       = COUNT_W_DEF,
    parameter int WINDOW        = 256,
    parameter int CLR_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 4
`ifdef RO_PUF_TIE_DETECT_EN
    ,
    parameter int TIE_MARGIN    = 4
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*SEL_W-1:0]   challenge,
    input  logic [COUNT_W-1:0]   count_a,
    input  logic [COUNT_W-1:0]   count_b,
    output logic [SEL_W-1:0]     sel_a,
    output logic [SEL_W-1:0]     sel_b,
    output logic                 ro_en,
    output logic                 cnt_clr,
    output logic                 busy,
    output logic                 done,
    output logic [N_BITS-1:0]    response
`ifdef RO_PUF_TIE_DETECT_EN
    ,
    output logic [N_BITS-1:0]    unstable
`endif
);

    localparam int PH_MAX = max3(WINDOW, CLR_CYCLES, SETTLE_CYCLES);
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int K_W    = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    localparam logic [PH_W-1:0] CLR_LD    = PH_W'(CLR_CYCLES - 1);
    localparam logic [PH_W-1:0] RUN_LD    = PH_W'(WINDOW - 1);
    localparam logic [PH_W-1:0] SETTLE_LD = PH_W'(SETTLE_CYCLES - 1);
    localparam logic [K_W-1:0]  K_LAST    = K_W'(N_BITS - 1);

    ro_puf_state_t      state;
    logic [PH_W-1:0]    timer;
    logic [K_W-1:0]     k;
    logic [2*SEL_W-1:0] chal_q;
    logic [SEL_W-1:0]   sel_a_nxt;
    logic [SEL_W-1:0]   sel_b_nxt;
    logic               tc;
    logic               cmp_bit;

    ro_puf_pair_sel #(
        .SEL_W (SEL_W),
        .K_W   (K_W)
    ) u_pair_sel (
        .challenge (chal_q),
        .k         (k),
        .sel_a     (sel_a_nxt),
        .sel_b     (sel_b_nxt)
    );

    assign tc      = (timer == '0);
    assign cmp_bit = (count_a > count_b);

`ifdef RO_PUF_TIE_DETECT_EN
    logic [COUNT_W-1:0] diff;
    logic               tie;

    assign diff = cmp_bit ? (count_a - count_b) : (count_b - count_a);
    assign tie  = (diff < COUNT_W'(TIE_MARGIN));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            k        <= '0;
            chal_q   <= '0;
            sel_a    <= '0;
            sel_b    <= '0;
            ro_en    <= 1'b0;
            cnt_clr  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            response <= '0;
`ifdef RO_PUF_TIE_DETECT_EN
            unstable <= '0;
`endif
        end else begin
            cnt_clr <= (state == CLEAR);
            ro_en   <= (state == RUN);
            done    <= (state == DONE);
            if (state == CLEAR) begin
                sel_a <= sel_a_nxt;
                sel_b <= sel_b_nxt;
            end

            case (state)
                IDLE: begin
                    // While done is high we are in the DONE cycle as seen
                    // from outside; a held start is taken one cycle later.
                    if (start && !done) begin
                        chal_q   <= challenge;
                        k        <= '0;
                        response <= '0;
`ifdef RO_PUF_TIE_DETECT_EN
                        unstable <= '0;
`endif
                        busy     <= 1'b1;
                        timer    <= CLR_LD;
                        state    <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (tc) begin
                        timer <= RUN_LD;
                        state <= RUN;
                    end else begin
                        timer <= timer - PH_W'(1);
                    end
                end
                RUN: begin
                    if (tc) begin
                        timer <= SETTLE_LD;
                        state <= SETTLE;
                    end else begin
                        timer <= timer - PH_W'(1);
                    end
                end
                SETTLE: begin
                    if (tc) begin
                        state <= COMPARE;
                    end else begin
                        timer <= timer - PH_W'(1);
                    end
                end
                COMPARE: begin
                    response[k] <= cmp_bit;
`ifdef RO_PUF_TIE_DETECT_EN
                    unstable[k] <= tie;
`endif
                    if (k == K_LAST) begin
                        state <= DONE;
                    end else begin
                        k     <= k + K_W'(1);
                        timer <= CLR_LD;
                        state <= CLEAR;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ro_puf_ctrl.sv
module tb_ro_puf_ctrl;

    localparam int N_BITS  = 8;
    localparam int SEL_W   = 5;
    localparam int COUNT_W = 16;
    localparam int EXP_LAT = 185;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [9:0]         challenge;
    logic [15:0]        count_a;
    logic [15:0]        count_b;
    logic [4:0]         sel_a;
    logic [4:0]         sel_b;
    logic               ro_en;
    logic               cnt_clr;
    logic               busy;
    logic               done;
    logic [7:0]         response;
`ifdef RO_PUF_TIE_DETECT_EN
    logic [7:0]         unstable;
`endif

    int checks   = 0;
    int failures = 0;
    int mode     = 0;

    always #5 clk = ~clk;

    ro_puf_ctrl #(
        .N_BITS        (N_BITS),
        .SEL_W         (SEL_W),
        .COUNT_W       (COUNT_W),
        .WINDOW        (16),
        .CLR_CYCLES    (2),
        .SETTLE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .challenge (challenge),
        .count_a   (count_a),
        .count_b   (count_b),
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .ro_en     (ro_en),
        .cnt_clr   (cnt_clr),
        .busy      (busy),
        .done      (done),
        .response  (response)
`ifdef RO_PUF_TIE_DETECT_EN
        ,
        .unstable  (unstable)
`endif
    );

    // Oscillator bank model: counts depend only on the selected oscillators.
    //   mode 0: count_a 100 if sel_a odd else 50, count_b 75
    //   mode 1: both counts equal
    //   mode 2: counts proportional to the oscillator index
    always_comb begin
        count_a = 16'd0;
        count_b = 16'd0;
        case (mode)
            0: begin
                count_a = sel_a[0] ? 16'd100 : 16'd50;
                count_b = 16'd75;
            end
            1: begin
                count_a = 16'd60;
                count_b = 16'd60;
            end
            default: begin
                count_a = {7'd0, sel_a, 4'd0};
                count_b = {7'd0, sel_b, 4'd0};
            end
        endcase
    end

    // Monitor: records the select pair at each counter-clear rise and counts
    // protocol violations and done pulses.
    logic       cnt_clr_q = 1'b0;
    logic       busy_q    = 1'b0;
    int         rec_n     = 0;
    logic [4:0] rec_a [8];
    logic [4:0] rec_b [8];
    int         coll_err  = 0;
    int         ovl_err   = 0;
    int         done_cnt  = 0;

    always @(negedge clk) begin
        cnt_clr_q <= cnt_clr;
        busy_q    <= busy;
        if (busy && !busy_q) begin
            rec_n <= 0;
        end else if (cnt_clr && !cnt_clr_q) begin
            if (rec_n < 8) begin
                rec_a[rec_n] <= sel_a;
                rec_b[rec_n] <= sel_b;
            end
            rec_n <= rec_n + 1;
        end
        if ((cnt_clr || ro_en) && (sel_a == sel_b)) coll_err <= coll_err + 1;
        if (cnt_clr && ro_en) ovl_err <= ovl_err + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns after the edge that samples start (the accept edge), +1.
    task automatic launch(input logic [4:0] a, input logic [4:0] b);
        challenge = {b, a};
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 4000) begin
            tick();
            lat++;
        end
    endtask

    typedef struct {
        logic [4:0] a;
        logic [4:0] b;
        int         mode;
        logic [7:0] resp;
        logic [7:0] unst;
        logic [4:0] sa0, sb0, sa2, sb2, sa7, sb7;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int lat;
        int w;
        int bad;
        int c0, o0, d0;

        vecs[0] = '{5'd3,  5'd10, 0, 8'h55, 8'h00, 5'd3,  5'd10, 5'd5,  5'd12, 5'd10, 5'd17};
        vecs[1] = '{5'd30, 5'd30, 0, 8'hAA, 8'h00, 5'd30, 5'd31, 5'd0,  5'd1,  5'd5,  5'd6};
        vecs[2] = '{5'd5,  5'd5,  1, 8'h00, 8'hFF, 5'd5,  5'd6,  5'd7,  5'd8,  5'd12, 5'd13};
        vecs[3] = '{5'd28, 5'd2,  2, 8'h0F, 8'h00, 5'd28, 5'd2,  5'd30, 5'd4,  5'd3,  5'd9};
        vecs[4] = '{5'd0,  5'd31, 2, 8'hFE, 8'h00, 5'd0,  5'd31, 5'd2,  5'd1,  5'd7,  5'd6};
        vecs[5] = '{5'd4,  5'd2,  2, 8'hFF, 8'h00, 5'd4,  5'd2,  5'd6,  5'd4,  5'd11, 5'd9};
        vecs[6] = '{5'd26, 5'd26, 2, 8'h20, 8'h00, 5'd26, 5'd27, 5'd28, 5'd29, 5'd1,  5'd2};

        // Reset then idle
        rst       = 1'b1;
        start     = 1'b0;
        challenge = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_sel_a",    sel_a,    0);
        check("rst_sel_b",    sel_b,    0);
        check("rst_ro_en",    ro_en,    0);
        check("rst_cnt_clr",  cnt_clr,  0);
        check("rst_busy",     busy,     0);
        check("rst_done",     done,     0);
        check("rst_response", response, 0);
`ifdef RO_PUF_TIE_DETECT_EN
        check("rst_unstable", unstable, 0);
`endif
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (ro_en || cnt_clr || busy || done || response != 0 || sel_a != 0 || sel_b != 0) bad++;
        end
        check("idle_quiet", bad, 0);

        // Table-driven evaluations
        for (int v = 0; v < 7; v++) begin
            mode = vecs[v].mode;
            c0 = coll_err;
            o0 = ovl_err;
            d0 = done_cnt;
            launch(vecs[v].a, vecs[v].b);
            check($sformatf("v%0d_busy_on_accept", v), busy, 1);
            wait_done(lat);
            check($sformatf("v%0d_latency", v), lat, EXP_LAT);
            check($sformatf("v%0d_busy_at_done", v), busy, 0);
            check($sformatf("v%0d_response", v), response, vecs[v].resp);
`ifdef RO_PUF_TIE_DETECT_EN
            check($sformatf("v%0d_unstable", v), unstable, vecs[v].unst);
`endif
            check($sformatf("v%0d_pairs", v), rec_n, 8);
            check($sformatf("v%0d_sel0", v), {rec_a[0], rec_b[0]}, {vecs[v].sa0, vecs[v].sb0});
            check($sformatf("v%0d_sel2", v), {rec_a[2], rec_b[2]}, {vecs[v].sa2, vecs[v].sb2});
            check($sformatf("v%0d_sel7", v), {rec_a[7], rec_b[7]}, {vecs[v].sa7, vecs[v].sb7});
            for (int i = 0; i < 5; i++) tick();
            check($sformatf("v%0d_hold", v), response, vecs[v].resp);
            check($sformatf("v%0d_collisions", v), coll_err - c0, 0);
            check($sformatf("v%0d_overlap", v), ovl_err - o0, 0);
            check($sformatf("v%0d_done_pulses", v), done_cnt - d0, 1);
        end

        // Reset during RUN of pair 3
        mode = 0;
        launch(5'd3, 5'd10);
        w = 0;
        while (!(rec_n == 4 && ro_en) && w < 500) begin
            tick();
            w++;
        end
        check("mr_reach_pair3", (w < 500), 1);
        check("mr_partial_resp", response, 8'h05);
        rst = 1'b1;
        tick();
        check("mr_ro_en",    ro_en,    0);
        check("mr_busy",     busy,     0);
        check("mr_response", response, 0);
        check("mr_cnt_clr",  cnt_clr,  0);
        check("mr_sel",      {sel_a, sel_b}, 0);
        rst = 1'b0;
        tick();
        launch(5'd3, 5'd10);
        wait_done(lat);
        check("mr_rerun_latency",  lat,      EXP_LAT);
        check("mr_rerun_response", response, 8'h55);
        for (int i = 0; i < 5; i++) tick();

        // start pulse with a new challenge during pair 5 is ignored
        d0 = done_cnt;
        launch(5'd3, 5'd10);
        w = 0;
        while (rec_n != 6 && w < 500) begin
            tick();
            w++;
        end
        check("sb_reach_pair5", (w < 500), 1);
        challenge = {5'd30, 5'd30};
        start     = 1'b1;
        tick();
        start     = 1'b0;
        check("sb_still_busy", busy, 1);
        wait_done(lat);
        check("sb_done_seen", done, 1);
        check("sb_response", response, 8'h55);
        for (int i = 0; i < 30; i++) tick();
        check("sb_done_pulses", done_cnt - d0, 1);

        // start held high: DONE-cycle start ignored, re-trigger one cycle later
        challenge = {5'd10, 5'd3};
        start     = 1'b1;
        tick();
        lat = 0;
        while (!done && lat < 4000) begin
            tick();
            lat++;
        end
        check("hold_first_done", lat, EXP_LAT);
        tick();
        lat++;
        check("hold_done_width", done, 0);
        check("hold_idle_gap", busy, 0);
        tick();
        lat++;
        start = 1'b0;
        check("hold_retrigger_busy", busy, 1);
        while (!done && lat < 4000) begin
            tick();
            lat++;
        end
        check("hold_second_done", lat, 2 * EXP_LAT + 2);
        check("hold_second_resp", response, 8'h55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
